// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared seven-segment definitions for the display scanner.
//   All patterns are high-true, bit order {g,f,e,d,c,b,a}.
//   Contents:
//     SEG_BLANK   pattern with every segment off
//     SEG_GLYPH   hex glyph table, index = nibble value (A,b,C,d,E,F)
//     hex_to_seg  nibble -> segment pattern lookup
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_GLYPH[nib];
    endfunction

endpackage

// File: rtl/hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
//   Combinational hex nibble to seven-segment decoder (high-true).
//   Ports:
//     i_nib  in   4   nibble to decode
//     o_seg  out  7   segment pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/seg_display_scan.sv
// -----------------------------------------------------------------------------
// seg_display_scan
//   Time-multiplexed driver for an N-digit seven-segment display. A prescaler
//   on the board clock produces a one-cycle scan tick; each tick advances the
//   selected digit. A loaded word waits in a pending register and is promoted
//   to the displayed (active) register only at a frame boundary, so a frame
//   never mixes two values.
//   Ports:
//     clk_board  in   1          board clock, all logic on posedge
//     rst_n      in   1          asynchronous active-low reset
//     value_i    in   32         hex word, nibble 0 = rightmost digit
//     dp_i       in   N_DIGITS   decimal point per digit, 1 = lit
//     load_i     in   1          strobe: capture value_i/dp_i
//     an_o       out  N_DIGITS   one-hot digit enable (polarity per ACTIVE_LOW)
//     seg_o      out  7          segments {g,f,e,d,c,b,a}
//     dp_o       out  1          decimal point of the selected digit
//     frame_o    out  1          pulse in the cycle after a frame boundary
// -----------------------------------------------------------------------------
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LEAD = 1
) (
    input  logic                clk_board,
    input  logic                rst_n,
    input  logic [31:0]         value_i,
    input  logic [N_DIGITS-1:0] dp_i,
    input  logic                load_i,
    output logic [N_DIGITS-1:0] an_o,
    output logic [6:0]          seg_o,
    output logic                dp_o,
    output logic                frame_o
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VW = 4 * N_DIGITS;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);

    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [VW-1:0]       r_pend_val;
    logic [N_DIGITS-1:0] r_pend_dp;
    logic                r_pend_vld;
    logic [VW-1:0]       r_act_val;
    logic [N_DIGITS-1:0] r_act_dp;
    logic [N_DIGITS-1:0] r_an;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic                r_frame;

    logic                w_tick;
    logic                w_swap;
    logic [3:0]          w_nib;
    logic                w_dp_sel;
    logic                w_blank_sel;
    logic                w_zero_run;
    logic [N_DIGITS-1:0] w_blank;
    logic [N_DIGITS-1:0] w_an;
    logic [6:0]          w_glyph;

    assign w_tick = (r_presc == PRESC_MAX);
    assign w_swap = w_tick && (r_idx == IDX_MAX);

    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // A load landing on the swap edge goes straight to active; otherwise it
    // parks in pending until the next frame boundary.
    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend_vld <= 1'b0;
            r_act_val  <= '0;
            r_act_dp   <= '0;
        end else if (w_swap) begin
            if (load_i) begin
                r_act_val <= value_i[VW-1:0];
                r_act_dp  <= dp_i;
            end else if (r_pend_vld) begin
                r_act_val <= r_pend_val;
                r_act_dp  <= r_pend_dp;
            end
            r_pend_vld <= 1'b0;
        end else if (load_i) begin
            r_pend_val <= value_i[VW-1:0];
            r_pend_dp  <= dp_i;
            r_pend_vld <= 1'b1;
        end
    end

    // Leading-zero mask built from the most significant digit downward:
    // a digit blanks while every nibble from it upward is zero.
    always_comb begin
        w_zero_run  = 1'b1;
        w_blank     = '0;
        w_an        = '0;
        w_nib       = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        for (int unsigned j = 0; j < N_DIGITS; j++) begin
            w_zero_run = w_zero_run &&
                         (r_act_val[4*(N_DIGITS-1-j) +: 4] == 4'h0);
            w_blank[N_DIGITS-1-j] = (BLANK_LEAD != 0) &&
                                    (N_DIGITS-1-j != 0) && w_zero_run;
        end
        for (int unsigned j = 0; j < N_DIGITS; j++) begin
            w_an[j] = (r_idx == IW'(j));
            if (r_idx == IW'(j)) begin
                w_nib       = r_act_val[4*j +: 4];
                w_dp_sel    = r_act_dp[j];
                w_blank_sel = w_blank[j];
            end
        end
    end

    hex7seg u_hex7seg (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            r_an    <= '0;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an;
            r_seg   <= w_blank_sel ? SEG_BLANK : w_glyph;
            r_dp    <= w_dp_sel;
            r_frame <= w_swap;
        end
    end

    // Internal state is high-true; only the pad-facing signals are inverted.
    assign an_o    = (ACTIVE_LOW != 0) ? ~r_an  : r_an;
    assign seg_o   = (ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign dp_o    = (ACTIVE_LOW != 0) ? ~r_dp  : r_dp;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_seg_display_scan.sv
module tb_seg_display_scan;

    logic        clk_board = 1'b0;
    logic        rst_n;
    logic [31:0] value_i;
    logic [7:0]  dp_i;
    logic [0:0]  dp_e;
    logic        load_i;

    logic [7:0]  an_o,  an_nb;
    logic [6:0]  seg_o, seg_nb, seg_e;
    logic        dp_o,  dp_nb, dp_eo;
    logic        frame_o, frame_nb, frame_e;
    logic [0:0]  an_e;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_board = ~clk_board;

    seg_display_scan #(.N_DIGITS(8), .SCAN_DIV(4), .ACTIVE_LOW(1), .BLANK_LEAD(1)) u_dut (
        .clk_board (clk_board), .rst_n (rst_n), .value_i (value_i), .dp_i (dp_i),
        .load_i (load_i), .an_o (an_o), .seg_o (seg_o), .dp_o (dp_o), .frame_o (frame_o)
    );

    seg_display_scan #(.N_DIGITS(8), .SCAN_DIV(4), .ACTIVE_LOW(1), .BLANK_LEAD(0)) u_dut_nb (
        .clk_board (clk_board), .rst_n (rst_n), .value_i (value_i), .dp_i (dp_i),
        .load_i (load_i), .an_o (an_nb), .seg_o (seg_nb), .dp_o (dp_nb), .frame_o (frame_nb)
    );

    seg_display_scan #(.N_DIGITS(1), .SCAN_DIV(1), .ACTIVE_LOW(1), .BLANK_LEAD(1)) u_dut_e (
        .clk_board (clk_board), .rst_n (rst_n), .value_i (value_i), .dp_i (dp_e),
        .load_i (load_i), .an_o (an_e), .seg_o (seg_e), .dp_o (dp_eo), .frame_o (frame_e)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_board);
    endtask

    task automatic wait_frame(input string tag);
        int cnt = 0;
        while (frame_o !== 1'b1 && cnt < 100) begin
            step(1);
            cnt++;
        end
        check_eq({tag, "_frame"}, {31'b0, frame_o}, 32'd1);
    endtask

    // Call at the negedge where frame_o is high; checks all 8 digit slots.
    // exp_seg / exp_nb are packed {d7,...,d0}, low-true segment patterns.
    task automatic check_frame(input string tag, input logic [55:0] exp_seg,
                               input logic [55:0] exp_nb, input logic [7:0] dp);
        logic [7:0] exp_an;
        logic       exp_dp;
        for (int k = 0; k < 8; k++) begin
            step((k == 0) ? 1 : 4);
            exp_an = 8'hFF ^ (8'h01 << k);
            exp_dp = ~dp[k];
            check_eq($sformatf("%s_an%0d", tag, k),  {24'b0, an_o},   {24'b0, exp_an});
            check_eq($sformatf("%s_seg%0d", tag, k), {25'b0, seg_o},  {25'b0, exp_seg[k*7 +: 7]});
            check_eq($sformatf("%s_nb%0d", tag, k),  {25'b0, seg_nb}, {25'b0, exp_nb[k*7 +: 7]});
            check_eq($sformatf("%s_dp%0d", tag, k),  {31'b0, dp_o},   {31'b0, exp_dp});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        value_i = 32'h0;
        dp_i    = 8'h00;
        dp_e    = 1'b1;
        load_i  = 1'b0;

        step(2);
        #1;
        check_eq("rst_an",    {24'b0, an_o},    32'hFF);
        check_eq("rst_seg",   {25'b0, seg_o},   32'h7F);
        check_eq("rst_dp",    {31'b0, dp_o},    32'd1);
        check_eq("rst_frame", {31'b0, frame_o}, 32'd0);
        check_eq("rst_an_e",  {31'b0, an_e},    32'd1);
        rst_n = 1'b1;
        step(7);

        // Reset asserted mid-count takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_an",  {24'b0, an_o},  32'hFF);
        check_eq("mid_rst_seg", {25'b0, seg_o}, 32'h7F);
        check_eq("mid_rst_dp",  {31'b0, dp_o},  32'd1);
        step(1);
        rst_n = 1'b1;

        step(1);
        check_eq("post_an",     {24'b0, an_o},   32'hFE);
        check_eq("post_seg",    {25'b0, seg_o},  32'h40);
        check_eq("post_dp",     {31'b0, dp_o},   32'd1);
        step(3);
        check_eq("hold_an",     {24'b0, an_o},   32'hFE);
        step(1);
        check_eq("adv_an",      {24'b0, an_o},   32'hFD);
        check_eq("adv_seg",     {25'b0, seg_o},  32'h7F);
        check_eq("adv_seg_nb",  {25'b0, seg_nb}, 32'h40);

        // Mid-frame load: held in pending, display untouched until frame end.
        value_i = 32'h1234_ABCD;
        dp_i    = 8'h05;
        load_i  = 1'b1;
        step(1);
        load_i  = 1'b0;
        check_eq("pend_vld_set", {31'b0, u_dut.r_pend_vld}, 32'd1);
        check_eq("notear_seg",   {25'b0, seg_o},            32'h7F);
        step(3);
        check_eq("notear_an",    {24'b0, an_o},             32'hFB);
        check_eq("notear_seg2",  {25'b0, seg_o},            32'h7F);
        wait_frame("ld");
        check_frame("ld",
            {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21},
            {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21},
            8'h05);

        // Leading-zero blanking.
        value_i = 32'h0000_00F0;
        dp_i    = 8'h00;
        load_i  = 1'b1;
        step(1);
        load_i  = 1'b0;
        wait_frame("blk");
        check_frame("blk",
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40},
            {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h0E, 7'h40},
            8'h00);

        // Load exactly on the final tick of digit 7 (swap edge): bypass.
        step(2);
        value_i = 32'h0000_5678;
        dp_i    = 8'h80;
        load_i  = 1'b1;
        step(1);
        load_i  = 1'b0;
        check_eq("co_frame",    {31'b0, frame_o},          32'd1);
        check_eq("co_pend_vld", {31'b0, u_dut.r_pend_vld}, 32'd0);
        check_frame("co",
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h02, 7'h78, 7'h00},
            {7'h40, 7'h40, 7'h40, 7'h40, 7'h12, 7'h02, 7'h78, 7'h00},
            8'h80);
        wait_frame("co2");
        step(1);
        check_eq("co_hold_seg", {25'b0, seg_o},            32'h00);
        check_eq("co_hold_pv",  {31'b0, u_dut.r_pend_vld}, 32'd0);

        // Two loads in one frame: only the second survives.
        value_i = 32'h1111_1111;
        dp_i    = 8'hFF;
        load_i  = 1'b1;
        step(1);
        load_i  = 1'b0;
        step(2);
        value_i = 32'h0000_00C3;
        dp_i    = 8'h00;
        load_i  = 1'b1;
        step(1);
        load_i  = 1'b0;
        wait_frame("b2b");
        check_frame("b2b",
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h46, 7'h30},
            {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h46, 7'h30},
            8'h00);

        // Single digit, tick every cycle.
        for (int i = 0; i < 4; i++) begin
            step(1);
            check_eq($sformatf("edge_an%0d", i),    {31'b0, an_e},    32'd0);
            check_eq($sformatf("edge_frame%0d", i), {31'b0, frame_e}, 32'd1);
            check_eq($sformatf("edge_dp%0d", i),    {31'b0, dp_eo},   32'd0);
            check_eq($sformatf("edge_seg%0d", i),   {25'b0, seg_e},   32'h30);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
